// File: rtl/tdm_pkg.sv
// Shared definitions for the 4:1 TDM demultiplexer: framing states, slot type, per-beat command.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a; the demux has no ready signal and in_valid alone gates every beat.
package tdm_pkg;

   // Number of time slots carried by one frame.
   localparam int SLOTS = 4;

   typedef logic [1:0] slot_t;

   localparam slot_t FIRST_SLOT = 2'd0;
   localparam slot_t LAST_SLOT  = slot_t'(SLOTS - 1);

   // Framing state: hunting for frame_sync, or locked onto the frame boundary.
   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } sync_state_t;

   // What the datapath does with the beat currently on in_data.
   //   store : write in_data into shadow register idx
   //   done  : beat completes a frame; publish shadows plus in_data
   typedef struct packed {
      logic  store;
      slot_t idx;
      logic  done;
   } beat_cmd_t;

   // Slot that follows s within a frame.
   function automatic slot_t next_slot(input slot_t s);
      return (s == LAST_SLOT) ? FIRST_SLOT : slot_t'(s + slot_t'(1));
   endfunction

endpackage

// File: rtl/tdm_sync_fsm.sv
// Frame alignment FSM: tracks the expected slot, counts missing frame_sync marks, flags violations.
// Latency: slot/locked/sync_err registered on the sampling edge; the beat command is same-cycle decode.
// Backpressure: none; state advances only on in_valid beats and holds otherwise.
module tdm_sync_fsm
   import tdm_pkg::*;
#(
   parameter int MISS_LIMIT = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      in_valid,
   input  logic      frame_sync,
   output beat_cmd_t cmd,
   output slot_t     slot,
   output logic      locked,
   output logic      sync_err
);

   // Counter only ever holds values below MISS_LIMIT before lock is dropped.
   localparam int MW = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);
   localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

   sync_state_t   state;
   logic [MW-1:0] miss_cnt;
   logic [MW-1:0] miss_inc;
   logic          miss_hit;

   assign miss_inc = miss_cnt + MW'(1);
   assign miss_hit = (miss_inc >= MISS_MAX);

   // Decode what the datapath must do with the beat being sampled this cycle.
   always_comb begin
      cmd = '0;
      if (in_valid) begin
         if (state == HUNT) begin
            // Only a marked beat starts a frame; everything else is dropped.
            if (frame_sync) begin
               cmd.store = 1'b1;
               cmd.idx   = FIRST_SLOT;
            end
         end else if (frame_sync) begin
            // A mark always re-anchors the frame, abandoning any partial one.
            cmd.store = 1'b1;
            cmd.idx   = FIRST_SLOT;
         end else if (slot == FIRST_SLOT) begin
            // Missing mark: keep the word unless this miss costs us lock.
            if (!miss_hit) begin
               cmd.store = 1'b1;
               cmd.idx   = FIRST_SLOT;
            end
         end else if (slot == LAST_SLOT) begin
            cmd.done = 1'b1;
         end else begin
            cmd.store = 1'b1;
            cmd.idx   = slot;
         end
      end
   end

   // Framing state, expected slot, miss counter and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HUNT;
         slot     <= FIRST_SLOT;
         miss_cnt <= '0;
         locked   <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         sync_err <= 1'b0;
         if (in_valid) begin
            if (state == HUNT) begin
               if (frame_sync) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  slot     <= next_slot(FIRST_SLOT);
                  miss_cnt <= '0;
               end
            end else if (frame_sync) begin
               // Mark where one was not expected is a framing violation.
               sync_err <= (slot != FIRST_SLOT);
               slot     <= next_slot(FIRST_SLOT);
               miss_cnt <= '0;
            end else if (slot == FIRST_SLOT) begin
               sync_err <= 1'b1;
               if (miss_hit) begin
                  state    <= HUNT;
                  locked   <= 1'b0;
                  slot     <= FIRST_SLOT;
                  miss_cnt <= '0;
               end else begin
                  miss_cnt <= miss_inc;
                  slot     <= next_slot(FIRST_SLOT);
               end
            end else begin
               slot <= next_slot(slot);
            end
         end
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// 4:1 TDM demultiplexer: collects slot words into shadows and publishes whole frames on out0..out3.
// Latency: outputs, out_valid and frame_cnt update on the same edge that samples the slot-3 beat.
// Backpressure: none; in_valid low freezes all state and forces out_valid low.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int WIDTH      = 2,
   parameter int MISS_LIMIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic             out_valid,
   output logic [1:0]       slot,
   output logic             locked,
   output logic             sync_err,
   output logic [7:0]       frame_cnt
);

   beat_cmd_t        cmd;
   slot_t            cur_slot;
   logic [WIDTH-1:0] shadow0;
   logic [WIDTH-1:0] shadow1;
   logic [WIDTH-1:0] shadow2;

   tdm_sync_fsm #(
      .MISS_LIMIT (MISS_LIMIT)
   ) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .frame_sync (frame_sync),
      .cmd        (cmd),
      .slot       (cur_slot),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   assign slot = cur_slot;

   // Capture slot 0..2 words; slot 3 goes straight to out3 so needs no shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow0 <= '0;
         shadow1 <= '0;
         shadow2 <= '0;
      end else if (cmd.store) begin
         case (cmd.idx)
            2'd0:    shadow0 <= in_data;
            2'd1:    shadow1 <= in_data;
            2'd2:    shadow2 <= in_data;
            default: ;
         endcase
      end
   end

   // Publish a complete frame atomically, pulse out_valid and count it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out0      <= '0;
         out1      <= '0;
         out2      <= '0;
         out3      <= '0;
         out_valid <= 1'b0;
         frame_cnt <= '0;
      end else begin
         out_valid <= 1'b0;
         if (cmd.done) begin
            out0      <= shadow0;
            out1      <= shadow1;
            out2      <= shadow2;
            out3      <= in_data;
            out_valid <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: frame-level reference model plus directed scenarios.
// Latency: model expects outputs one edge after the sampled beat, matching registered outputs.
// Backpressure: stimulus inserts in_valid gaps; no ready path exists.
module tb_tdm_demux;

   localparam int W  = 2;
   localparam int ML = 2;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         frame_sync;
   logic [W-1:0] out0, out1, out2, out3;
   logic         out_valid;
   logic [1:0]   slot;
   logic         locked;
   logic         sync_err;
   logic [7:0]   frame_cnt;

   int total = 0;
   int bad   = 0;
   int ov_seen  = 0;
   int err_seen = 0;

   tdm_demux #(
      .WIDTH      (W),
      .MISS_LIMIT (ML)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .frame_sync (frame_sync),
      .out0       (out0),
      .out1       (out1),
      .out2       (out2),
      .out3       (out3),
      .out_valid  (out_valid),
      .slot       (slot),
      .locked     (locked),
      .sync_err   (sync_err),
      .frame_cnt  (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The frame in progress is a queue of received words; its length is the next slot.
   logic [W-1:0] m_part[$];
   logic [W-1:0] e_out[4];
   bit           m_lock = 0;
   int           m_miss = 0;
   bit           e_ov   = 0;
   bit           e_err  = 0;
   int           e_cnt  = 0;

   task automatic m_reset();
      m_part.delete();
      m_lock = 0;
      m_miss = 0;
      e_ov   = 0;
      e_err  = 0;
      e_cnt  = 0;
      for (int i = 0; i < 4; i++) e_out[i] = '0;
   endtask

   task automatic m_step();
      e_ov  = 0;
      e_err = 0;
      if (!in_valid) return;
      if (!m_lock) begin
         if (frame_sync) begin
            m_lock = 1;
            m_miss = 0;
            m_part.delete();
            m_part.push_back(in_data);
         end
      end else if (frame_sync) begin
         e_err  = (m_part.size() != 0);
         m_miss = 0;
         m_part.delete();
         m_part.push_back(in_data);
      end else if (m_part.size() == 0) begin
         e_err = 1;
         m_miss++;
         if (m_miss >= ML) begin
            m_lock = 0;
            m_miss = 0;
         end else begin
            m_part.push_back(in_data);
         end
      end else begin
         m_part.push_back(in_data);
         if (m_part.size() == 4) begin
            for (int i = 0; i < 4; i++) e_out[i] = m_part[i];
            e_ov  = 1;
            e_cnt = (e_cnt + 1) % 256;
            m_part.delete();
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else        m_step();
   end

   // Compare every output against the model on every falling edge.
   always @(negedge clk) begin
      chk("out0", out0, e_out[0]);
      chk("out1", out1, e_out[1]);
      chk("out2", out2, e_out[2]);
      chk("out3", out3, e_out[3]);
      chk("out_valid", out_valid, e_ov);
      chk("sync_err", sync_err, e_err);
      chk("locked", locked, m_lock);
      chk("slot", slot, m_lock ? m_part.size() : 0);
      chk("frame_cnt", frame_cnt, e_cnt);
      if (out_valid) ov_seen++;
      if (sync_err)  err_seen++;
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit v, input bit fs, input logic [W-1:0] d);
      @(negedge clk);
      #1;
      in_valid   = v;
      frame_sync = fs;
      in_data    = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0);
   endtask

   task automatic send_frame(input logic [W-1:0] d0, input logic [W-1:0] d1,
                             input logic [W-1:0] d2, input logic [W-1:0] d3, input bit fs);
      drive(1'b1, fs,   d0);
      drive(1'b1, 1'b0, d1);
      drive(1'b1, 1'b0, d2);
      drive(1'b1, 1'b0, d3);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic chk_outs(input string tag, input int a, input int b, input int c, input int d);
      chk({tag, "_out0"}, out0, a);
      chk({tag, "_out1"}, out1, b);
      chk({tag, "_out2"}, out2, c);
      chk({tag, "_out3"}, out3, d);
   endtask

   initial begin
      int ov_base;
      int err_base;
      logic [W-1:0] r[4];

      in_valid   = 1'b0;
      frame_sync = 1'b0;
      in_data    = '0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      chk_outs("rst", 0, 0, 0, 0);
      chk("rst_locked", locked, 0);
      chk("rst_cnt", frame_cnt, 0);

      // Two back-to-back synced frames
      ov_base = ov_seen;
      send_frame(2'd1, 2'd2, 2'd3, 2'd0, 1'b1);
      idle();
      chk_outs("f1", 1, 2, 3, 0);
      send_frame(2'd3, 2'd3, 2'd0, 2'd1, 1'b1);
      idle();
      chk_outs("f2", 3, 3, 0, 1);
      chk("f2_cnt", frame_cnt, 2);
      chk("f2_ovs", ov_seen - ov_base, 2);

      // in_valid gap between beats 1 and 2
      ov_base = ov_seen;
      drive(1'b1, 1'b1, 2'd2);
      drive(1'b1, 1'b0, 2'd1);
      idle(); idle(); idle();
      chk("gap_ov", ov_seen - ov_base, 0);
      chk("gap_slot", slot, 2);
      drive(1'b1, 1'b0, 2'd3);
      drive(1'b1, 1'b0, 2'd0);
      idle();
      chk_outs("gap", 2, 1, 3, 0);
      chk("gap_cnt", frame_cnt, 3);
      chk("gap_ovs", ov_seen - ov_base, 1);

      // frame_sync on beat 2 while locked
      err_base = err_seen;
      ov_base  = ov_seen;
      drive(1'b1, 1'b1, 2'd1);
      drive(1'b1, 1'b0, 2'd2);
      drive(1'b1, 1'b1, 2'd3);
      idle();
      chk("resync_err", err_seen - err_base, 1);
      chk("resync_slot", slot, 1);
      chk("resync_ov", ov_seen - ov_base, 0);
      chk_outs("resync_hold", 2, 1, 3, 0);
      drive(1'b1, 1'b0, 2'd0);
      drive(1'b1, 1'b0, 2'd1);
      drive(1'b1, 1'b0, 2'd2);
      idle();
      chk_outs("resync", 3, 0, 1, 2);
      chk("resync_cnt", frame_cnt, 4);

      // Two frames without frame_sync drop lock
      err_base = err_seen;
      ov_base  = ov_seen;
      send_frame(2'd0, 2'd1, 2'd2, 2'd3, 1'b0);
      send_frame(2'd0, 2'd2, 2'd2, 2'd2, 1'b0);
      idle();
      chk("miss_err", err_seen - err_base, 2);
      chk("miss_ov", ov_seen - ov_base, 1);
      chk("miss_locked", locked, 0);
      chk("miss_slot", slot, 0);
      chk_outs("miss", 0, 1, 2, 3);
      chk("miss_cnt", frame_cnt, 5);
      send_frame(2'd1, 2'd1, 2'd1, 2'd1, 1'b1);
      idle();
      chk_outs("relock", 1, 1, 1, 1);
      chk("relock_cnt", frame_cnt, 6);

      // Reset during beat 2
      ov_base = ov_seen;
      drive(1'b1, 1'b1, 2'd2);
      drive(1'b1, 1'b0, 2'd2);
      @(negedge clk);
      #1;
      rst_n      = 1'b0;
      in_valid   = 1'b1;
      frame_sync = 1'b0;
      in_data    = 2'd3;
      idle();
      chk_outs("midrst", 0, 0, 0, 0);
      chk("midrst_locked", locked, 0);
      chk("midrst_cnt", frame_cnt, 0);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 2'd3);
      drive(1'b1, 1'b0, 2'd1);
      idle();
      chk("midrst_nolock", locked, 0);
      chk("midrst_ov", ov_seen - ov_base, 0);
      send_frame(2'd3, 2'd2, 2'd1, 2'd0, 1'b1);
      idle();
      chk_outs("postrst", 3, 2, 1, 0);
      chk("postrst_cnt", frame_cnt, 1);

      // 256 frames: counter wraps to 0
      do_reset();
      ov_base = ov_seen;
      for (int f = 0; f < 256; f++) begin
         for (int i = 0; i < 4; i++) r[i] = W'($urandom_range(0, 3));
         send_frame(r[0], r[1], r[2], r[3], 1'b1);
         if (f == 254) begin
            idle();
            chk("wrap_255", frame_cnt, 255);
         end
      end
      idle();
      chk_outs("wrap", r[0], r[1], r[2], r[3]);
      chk("wrap_cnt", frame_cnt, 0);
      chk("wrap_ovs", ov_seen - ov_base, 256);

      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 2, giving the bit width of each channel word.
REQ-002 SHALL have parameter MISS_LIMIT, default 2, giving the consecutive missing frame_sync count that drops lock.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  in_data and frame_sync are sampled only when high.
REQ-007 in_data  input  WIDTH  time-multiplexed word from a 4:1 slot mux.
REQ-008 frame_sync  input  1  marks the beat carrying slot 0.
REQ-009 out0, out1, out2, out3  output  WIDTH each  registered demultiplexed channel words.
REQ-010 out_valid  output  1  one-cycle pulse when out0..out3 have just been updated with a complete frame.
REQ-011 slot  output  2  slot index expected on the next valid beat.
REQ-012 locked  output  1  high in the LOCKED state.
REQ-013 sync_err  output  1  one-cycle pulse on any framing violation.
REQ-014 frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-015 SHALL implement a two-state FSM: HUNT and LOCKED.
REQ-016 In HUNT, beats without frame_sync SHALL be discarded; slot SHALL be held at 0.
REQ-017 In HUNT, a valid beat with frame_sync SHALL store in_data as slot 0, set slot=1, and move to LOCKED.
REQ-018 In LOCKED, each valid beat SHALL store in_data into the shadow register for the current slot, then increment slot modulo 4.
REQ-019 A valid beat at slot 3 SHALL load out0..out2 from the shadows and out3 from in_data, all on the same edge.
REQ-020 On that same edge, out_valid SHALL be set for one cycle and frame_cnt SHALL be incremented.
REQ-021 Latency from the slot-3 beat sample edge to out_valid high SHALL be 0 cycles: both are registered on the same edge.
REQ-022 When in_valid is low, the FSM, slot, shadows, and outputs SHALL hold, and out_valid SHALL be 0.
REQ-023 In LOCKED, frame_sync at slot!=0 SHALL have three effects:
- pulse sync_err;
- discard the partial frame, with no output update;
- store this beat as slot 0 and set slot=1.
REQ-024 In LOCKED, a valid beat at slot==0 without frame_sync SHALL have three effects:
- pulse sync_err;
- increment the miss counter;
- still be stored as slot 0.
REQ-025 When the miss counter reaches MISS_LIMIT, the FSM SHALL go to HUNT, set slot=0, and discard that beat.
REQ-026 A valid slot-0 beat with frame_sync SHALL clear the miss counter.
REQ-027 out0..out3 SHALL hold their last frame until the next complete frame; partial frames never update them.
REQ-028 frame_cnt SHALL wrap from 255 to 0 with no flag.

Reset
REQ-029 While rst_n is low, the block SHALL set:
- FSM=HUNT, slot=0, miss counter=0;
- shadows=0, out0..out3=0;
- out_valid=0, sync_err=0, locked=0, frame_cnt=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no out_valid pulse.
REQ-031 After rst_n deasserts, the block SHALL re-acquire only via frame_sync.

Structure
REQ-032 The state encoding (HUNT, LOCKED) and the slot count constant 4 SHALL live in the shared package tdm_pkg.
REQ-033 The FSM and the miss counter SHALL be one sub-module, tdm_sync_fsm; the datapath SHALL stay in tdm_demux.

Verification
REQ-034 Reset then frames {1,2,3,0}, {3,3,0,1} (WIDTH=2, frame_sync on beat 0) -> out_valid twice; outputs 1,2,3,0 then 3,3,0,1; frame_cnt=2.
REQ-035 Frame with in_valid low for 3 cycles between beats 1 and 2 -> no out_valid until the slot-3 beat; outputs correct.
REQ-036 frame_sync asserted on beat 2 while LOCKED -> sync_err pulse, no output update, slot=1 next, following frame outputs correct.
REQ-037 Two consecutive frames missing frame_sync (MISS_LIMIT=2) -> two sync_err pulses, locked falls, beats ignored until the next frame_sync.
REQ-038 rst_n low during beat 2 -> all outputs 0, locked=0, no out_valid; the next synced frame is captured normally.
REQ-039 256 complete frames -> frame_cnt wraps to 0; out_valid count is 256.
